// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload pass-through, padding, optional FCS, inter-frame gap.
// Define ETH_TX_FCS_EN to build the CRC-32 generator and append the 4-byte FCS.
`timescale 1ns/1ps
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12,
  parameter int CNT_W        = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic       frame_done,
  output logic       underrun,
  output logic       busy
);

  localparam int PH_W = 16;
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0] PRE_LAST = PH_W'(PREAMBLE_LEN - 1);
  localparam logic [PH_W-1:0] IFG_LAST = PH_W'(IFG_BYTES - 1);
  localparam logic [CNT_W:0]  MIN_LEN  = (CNT_W+1)'(MIN_FRAME);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD,
`ifdef ETH_TX_FCS_EN
    ST_FCS,
`endif
    ST_IFG
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    cnt_plus;
  logic [CNT_W-1:0]  cnt_sat;

  // cnt_plus is one bit wider so the MIN_FRAME compare still works once cnt saturates
  assign cnt_plus = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_sat  = (&cnt) ? cnt : cnt_plus[CNT_W-1:0];

`ifdef ETH_TX_FCS_EN
  localparam logic [PH_W-1:0] FCS_LAST = PH_W'(3);
  logic [31:0] crc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      cnt        <= '0;
      s_ready    <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_txen  <= 1'b0;
      gmii_txer  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
`ifdef ETH_TX_FCS_EN
      crc        <= 32'hFFFFFFFF;
`endif
    end else begin
      gmii_txer  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          gmii_txen <= 1'b0;
          gmii_txd  <= 8'h00;
          if (s_valid) begin
            state <= ST_PRE;
            phase <= '0;
            busy  <= 1'b1;
          end
        end
        ST_PRE: begin
          gmii_txen <= 1'b1;
          gmii_txd  <= 8'h55;
          if (phase == PRE_LAST) begin
            phase <= '0;
            state <= ST_SFD;
          end else begin
            phase <= phase + PH_ONE;
          end
        end
        ST_SFD: begin
          gmii_txen <= 1'b1;
          gmii_txd  <= 8'hD5;
          cnt       <= '0;
          s_ready   <= 1'b1;
          state     <= ST_DATA;
`ifdef ETH_TX_FCS_EN
          crc       <= 32'hFFFFFFFF;
`endif
        end
        ST_DATA: begin
          gmii_txen <= 1'b1;
          if (s_valid) begin
            gmii_txd <= s_data;
            cnt      <= cnt_sat;
`ifdef ETH_TX_FCS_EN
            crc      <= crc32_byte(crc, s_data);
`endif
            if (s_last) begin
              s_ready <= 1'b0;
              phase   <= '0;
              if (cnt_plus < MIN_LEN) begin
                state <= ST_PAD;
              end else begin
`ifdef ETH_TX_FCS_EN
                state      <= ST_FCS;
`else
                state      <= ST_IFG;
                frame_done <= 1'b1;
`endif
              end
            end
          end else begin
            // Source starved mid-frame: poison the frame on the wire and skip the FCS
            gmii_txd  <= 8'h00;
            gmii_txer <= 1'b1;
            underrun  <= 1'b1;
            s_ready   <= 1'b0;
            phase     <= '0;
            state     <= ST_IFG;
          end
        end
        ST_PAD: begin
          gmii_txen <= 1'b1;
          gmii_txd  <= 8'h00;
          cnt       <= cnt_sat;
`ifdef ETH_TX_FCS_EN
          crc       <= crc32_byte(crc, 8'h00);
`endif
          if (cnt_plus >= MIN_LEN) begin
            phase <= '0;
`ifdef ETH_TX_FCS_EN
            state      <= ST_FCS;
`else
            state      <= ST_IFG;
            frame_done <= 1'b1;
`endif
          end
        end
`ifdef ETH_TX_FCS_EN
        ST_FCS: begin
          gmii_txen <= 1'b1;
          gmii_txd  <= ~crc[7:0];
          crc       <= {8'hFF, crc[31:8]};
          if (phase == FCS_LAST) begin
            frame_done <= 1'b1;
            phase      <= '0;
            state      <= ST_IFG;
          end else begin
            phase <= phase + PH_ONE;
          end
        end
`endif
        ST_IFG: begin
          gmii_txen <= 1'b0;
          gmii_txd  <= 8'h00;
          if (phase == IFG_LAST) begin
            phase <= '0;
            // Going straight to PRE keeps back-to-back frames at exactly IFG_BYTES idle cycles
            if (s_valid) begin
              state <= ST_PRE;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            phase <= phase + PH_ONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          s_ready   <= 1'b0;
          gmii_txen <= 1'b0;
          gmii_txd  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: two instances (MIN_FRAME 0 and 60), wire streams checked against a byte model.
`timescale 1ns/1ps
module tb_gmii_tx_framer;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic [7:0] s_data;
  logic       s_valid, s_last;
  logic       v0, v60;
  logic       r0, txen0, txer0, fd0, ur0, busy0;
  logic       r60, txen60, txer60, fd60, ur60, busy60;
  logic [7:0] txd0, txd60;
  logic       r_m, txen_m, txer_m, fd_m, ur_m, busy_m;
  logic [7:0] txd_m;

  assign v0  = s_valid & ~sel;
  assign v60 = s_valid & sel;
  assign r_m    = sel ? r60    : r0;
  assign txen_m = sel ? txen60 : txen0;
  assign txer_m = sel ? txer60 : txer0;
  assign fd_m   = sel ? fd60   : fd0;
  assign ur_m   = sel ? ur60   : ur0;
  assign busy_m = sel ? busy60 : busy0;
  assign txd_m  = sel ? txd60  : txd0;

  gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_BYTES(12), .CNT_W(11)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(v0), .s_last(s_last), .s_ready(r0),
    .gmii_txd(txd0), .gmii_txen(txen0), .gmii_txer(txer0), .frame_done(fd0), .underrun(ur0), .busy(busy0));

  gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12), .CNT_W(11)) dut60 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(v60), .s_last(s_last), .s_ready(r60),
    .gmii_txd(txd60), .gmii_txen(txen60), .gmii_txer(txer60), .frame_done(fd60), .underrun(ur60), .busy(busy60));

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] src[$];
  logic [7:0] exp_bytes[$], got_bytes[$], exp_last[$], got_fd_bytes[$];
  int exp_runs[$], got_runs[$], exp_gaps[$], got_gaps[$];
  int exp_txer, exp_ur, got_txer, got_txer_bad, got_fd_bad, got_ur, acc_cnt, first_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] got_byte(input int i);
    if (i < got_bytes.size()) return 32'(got_bytes[i]);
    return 32'hDEAD;
  endfunction

  function automatic logic [31:0] got_run0();
    if (got_runs.size() > 0) return 32'(got_runs[0]);
    return 32'hDEAD;
  endfunction

  function automatic logic [31:0] got_fd0();
    if (got_fd_bytes.size() > 0) return 32'(got_fd_bytes[0]);
    return 32'hDEAD;
  endfunction

  task automatic clear_all();
    src.delete(); exp_bytes.delete(); exp_runs.delete(); exp_gaps.delete(); exp_last.delete();
    exp_txer = 0; exp_ur = 0;
  endtask

  task automatic add_src(input int len, input int seed);
    for (int i = 0; i < len; i++) src.push_back({(i == len - 1), 8'(seed + i)});
  endtask

  // Expected wire image of one frame: preamble, SFD, payload, then either abort byte or pad+FCS
  task automatic add_exp(input int len, input int seed, input int minf, input bit aborted);
    logic [31:0] c;
    logic [7:0]  b;
    int run;
    c = 32'hFFFFFFFF;
    run = 0;
    for (int i = 0; i < 7; i++) begin exp_bytes.push_back(8'h55); run++; end
    exp_bytes.push_back(8'hD5); run++;
    for (int i = 0; i < len; i++) begin
      b = 8'(seed + i);
      exp_bytes.push_back(b); c = crc_step(c, b); run++;
    end
    if (aborted) begin
      exp_bytes.push_back(8'h00); run++;
      exp_txer++; exp_ur++;
    end else begin
      b = 8'h00;
      for (int i = len; i < minf; i++) begin exp_bytes.push_back(8'h00); c = crc_step(c, 8'h00); run++; end
`ifdef ETH_TX_FCS_EN
      c = ~c;
      for (int k = 0; k < 4; k++) begin b = c[8*k +: 8]; exp_bytes.push_back(b); run++; end
`else
      if (len < minf) b = 8'h00; else b = 8'(seed + len - 1);
`endif
      exp_last.push_back(b);
    end
    exp_runs.push_back(run);
  endtask

  task automatic run(input int cycles, input int drop_at, input int rst_at);
    int idx, run_len, gap;
    bit pend, dropped, seen_on, rst_done;
    idx = 0; run_len = 0; gap = 0; pend = 0; dropped = 0; seen_on = 0; rst_done = 0;
    got_bytes.delete(); got_runs.delete(); got_gaps.delete(); got_fd_bytes.delete();
    got_txer = 0; got_txer_bad = 0; got_fd_bad = 0; got_ur = 0; acc_cnt = 0; first_on = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (txen_m) begin
        if (run_len == 0 && seen_on) got_gaps.push_back(gap);
        if (!seen_on) first_on = c;
        seen_on = 1; got_bytes.push_back(txd_m); run_len++; gap = 0;
      end else begin
        if (run_len > 0) begin got_runs.push_back(run_len); run_len = 0; end
        if (seen_on) gap++;
      end
      if (txer_m) begin got_txer++; if (!(txen_m && txd_m == 8'h00)) got_txer_bad++; end
      if (fd_m) begin got_fd_bytes.push_back(txd_m); if (!txen_m) got_fd_bad++; end
      if (ur_m) got_ur++;
      if (!rst_n) rst_n = 1'b1;
      if (pend) idx++;
      if (rst_at > 0 && !rst_done && got_bytes.size() == rst_at) begin
        rst_done = 1;
        rst_n = 1'b0;
        #1;
        check("rst_async_txen", 32'(txen_m), 32'h0);
        check("rst_async_txer", 32'(txer_m), 32'h0);
        check("rst_async_txd",  32'(txd_m),  32'h0);
        check("rst_async_busy", 32'(busy_m), 32'h0);
        idx = src.size();
      end
      if (idx < src.size() && !(idx == drop_at && !dropped)) begin
        s_valid = 1'b1; s_data = src[idx][7:0]; s_last = src[idx][8];
      end else begin
        if (idx == drop_at) dropped = 1;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      end
      pend = s_valid && r_m;
      if (pend) acc_cnt++;
    end
    if (run_len > 0) got_runs.push_back(run_len);
  endtask

  task automatic analyze(input string t);
    check({t, ":frames"}, 32'(got_runs.size()), 32'(exp_runs.size()));
    for (int i = 0; i < exp_runs.size() && i < got_runs.size(); i++)
      check({t, ":frame_len"}, 32'(got_runs[i]), 32'(exp_runs[i]));
    check({t, ":gaps"}, 32'(got_gaps.size()), 32'(exp_gaps.size()));
    for (int i = 0; i < exp_gaps.size() && i < got_gaps.size(); i++)
      check({t, ":gap_len"}, 32'(got_gaps[i]), 32'(exp_gaps[i]));
    check({t, ":nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      check($sformatf("%s:byte%0d", t, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    check({t, ":txer_cnt"}, 32'(got_txer), 32'(exp_txer));
    check({t, ":txer_shape"}, 32'(got_txer_bad), 32'h0);
    check({t, ":underrun_cnt"}, 32'(got_ur), 32'(exp_ur));
    check({t, ":done_cnt"}, 32'(got_fd_bytes.size()), 32'(exp_last.size()));
    for (int i = 0; i < exp_last.size() && i < got_fd_bytes.size(); i++)
      check({t, ":done_byte"}, 32'(got_fd_bytes[i]), 32'(exp_last[i]));
    check({t, ":done_txen"}, 32'(got_fd_bad), 32'h0);
    check({t, ":end_busy"}, 32'(busy_m), 32'h0);
    check({t, ":end_ready"}, 32'(r_m), 32'h0);
    $display("[%s] %0d frame(s), %0d bytes on wire, %0d accepted", t, got_runs.size(), got_bytes.size(), acc_cnt);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:txen0", 32'(txen0), 32'h0);   check("reset:txd0", 32'(txd0), 32'h0);
    check("reset:txer0", 32'(txer0), 32'h0);   check("reset:busy0", 32'(busy0), 32'h0);
    check("reset:ready0", 32'(r0), 32'h0);     check("reset:done0", 32'(fd0), 32'h0);
    check("reset:txen60", 32'(txen60), 32'h0); check("reset:busy60", 32'(busy60), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle:txen0", 32'(txen0), 32'h0);
    check("idle:ready0", 32'(r0), 32'h0);

    // "123456789" with no padding
    clear_all(); sel = 1'b0;
    add_src(9, 8'h31); add_exp(9, 8'h31, 0, 0);
    run(50, -1, -1);
    analyze("t1");
    check("t1:latency", 32'(first_on), 32'd2);
    check("t1:accepted", 32'(acc_cnt), 32'd9);
`ifdef ETH_TX_FCS_EN
    check("t1:len21", got_run0(), 32'd21);
    check("t1:fcs0", got_byte(17), 32'h26);
    check("t1:fcs1", got_byte(18), 32'h39);
    check("t1:fcs2", got_byte(19), 32'hF4);
    check("t1:fcs3", got_byte(20), 32'hCB);
    check("t1:done_on_CB", got_fd0(), 32'hCB);
`else
    check("t1:len17", got_run0(), 32'd17);
    check("t1:done_on_39", got_fd0(), 32'h39);
`endif

    // single byte padded to 60
    clear_all(); sel = 1'b1;
    add_src(1, 8'hAA); add_exp(1, 8'hAA, 60, 0);
    run(100, -1, -1);
    analyze("t2");
    check("t2:accepted", 32'(acc_cnt), 32'd1);
`ifdef ETH_TX_FCS_EN
    check("t2:len72", got_run0(), 32'd72);
`else
    check("t2:len68", got_run0(), 32'd68);
`endif

    // two 64-byte frames back to back, s_valid held high
    clear_all(); sel = 1'b1;
    add_src(64, 8'h00); add_src(64, 8'h80);
    add_exp(64, 8'h00, 60, 0); exp_gaps.push_back(12); add_exp(64, 8'h80, 60, 0);
    run(200, -1, -1);
    analyze("t3");
    check("t3:accepted", 32'(acc_cnt), 32'd128);

    // one-cycle source hole after 10 bytes: abort, 12 idle, rest of stream becomes a new padded frame
    clear_all(); sel = 1'b1;
    add_src(20, 8'h10);
    add_exp(10, 8'h10, 0, 1); exp_gaps.push_back(12); add_exp(10, 8'h1A, 60, 0);
    run(150, 10, -1);
    analyze("t4");

    // asynchronous reset in the middle of the frame tail, then a clean frame
    clear_all(); sel = 1'b0;
    add_src(9, 8'h31);
`ifdef ETH_TX_FCS_EN
    run(40, -1, 20);
`else
    run(40, -1, 12);
`endif
    check("t5:reset_seen", 32'(rst_n), 32'h1);
    clear_all(); sel = 1'b0;
    add_src(9, 8'h31); add_exp(9, 8'h31, 0, 0);
    run(50, -1, -1);
    analyze("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
